// File: rtl/rd_burst_arb.sv
// rtl/rd_burst_arb.sv - round-robin burst arbiter for a shared FIFO read port
module rd_burst_arb #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                     rd_clk,
  input  logic                     rst,
  input  logic                     empty,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic                     rd_en_sys,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       data_vld,
  output logic                     done,
  output logic                     abort,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_END   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gidx;
  logic [LEN_W-1:0] beat_cnt;
  logic [7:0]       empty_cnt;

  logic [LEN_W-1:0] len_arr [NUM_REQ];
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [LEN_W-1:0] pick_len;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign len_arr[i] = req_len[i*LEN_W +: LEN_W];
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
    pick_len = len_arr[pick_idx];
  end

  assign rd_en_sys = ~rst & (state == S_BURST) & ~empty & req[gidx];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      beat_cnt  <= '0;
      empty_cnt <= '0;
      gnt       <= '0;
      data_vld  <= '0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      data_vld <= rd_en_sys ? gnt : '0;
      done     <= 1'b0;
      abort    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt       <= NUM_REQ'(1) << pick_idx;
            gidx      <= pick_idx;
            beat_cnt  <= pick_len;
            empty_cnt <= '0;
            state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (!req[gidx]) begin
            gnt   <= '0;
            abort <= 1'b1;
            state <= S_END;
          end else if (empty) begin
            // The TIMEOUT-th consecutive empty cycle ends the burst.
            if (empty_cnt == TO_LAST) begin
              gnt   <= '0;
              abort <= 1'b1;
              state <= S_END;
            end else begin
              empty_cnt <= empty_cnt + 8'd1;
            end
          end else begin
            empty_cnt <= '0;
            if (beat_cnt == '0) begin
              gnt   <= '0;
              done  <= 1'b1;
              state <= S_END;
            end else begin
              beat_cnt <= beat_cnt - LEN_W'(1);
            end
          end
        end
        S_END: begin
          rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + IDX_W'(1);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_burst_arb.sv
// tb/tb_rd_burst_arb.sv - scoreboard bench for rd_burst_arb
module tb_rd_burst_arb;

  localparam int K_GNT = 0;
  localparam int K_VLD = 1;
  localparam int K_END = 2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty;
  logic [3:0]  req;
  logic [11:0] req_len;
  logic        rd_en_sys;
  logic [3:0]  gnt;
  logic [3:0]  data_vld;
  logic        done;
  logic        abort;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   end_cyc = 0;
  int   gcyc[$];
  ev_t  exq[$];
  logic [3:0] prev_gnt = 4'd0;

  rd_burst_arb #(.NUM_REQ(4), .LEN_W(3), .TIMEOUT(16)) dut (
    .rd_clk    (clk),
    .rst       (rst),
    .empty     (empty),
    .req       (req),
    .req_len   (req_len),
    .rd_en_sys (rd_en_sys),
    .gnt       (gnt),
    .data_vld  (data_vld),
    .done      (done),
    .abort     (abort),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] v);
    ev_t e;
    e.kind = 2'(kind);
    e.val  = v;
    exq.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] v);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d value %0h expected nothing (cycle %0d)", kind, v, cyc);
    end else begin
      e = exq.pop_front();
      if (32'(e.kind) != 32'(kind) || e.val !== v) begin
        errors++;
        $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h (cycle %0d)",
                 kind, v, e.kind, e.val, cyc);
      end
    end
  endtask

  // Monitor: grant edges, read-data markers and burst endings, in that order per cycle.
  always @(negedge clk) begin
    if (gnt != 4'd0 && prev_gnt == 4'd0) begin
      gcyc.push_back(cyc);
      pop_cmp(K_GNT, {4'd0, gnt});
    end
    prev_gnt = gnt;
    if (data_vld != 4'd0) pop_cmp(K_VLD, {4'd0, data_vld});
    if (done || abort) begin
      end_cyc = cyc;
      pop_cmp(K_END, {6'd0, done, abort});
    end
    if (done && abort) chk("done_abort_exclusive", 32'({done, abort}), 32'b10);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; req = '0; empty = 1'b0; req_len = '0;
    tick();
    tick();
    @(negedge clk);
    chk(name, 32'({rd_en_sys, gnt, data_vld, done, abort, busy}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (done || abort) got = 1'b1;
    end
    if (!got) chk({name, "_end_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_gnt(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (gnt != 4'd0) got = 1'b1;
    end
    if (!got) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rd(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (rd_en_sys) got = 1'b1;
    end
    if (!got) chk({name, "_rd_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single burst of 4 beats from requester 0.
    do_reset("s1_reset");
    expect_ev(K_GNT, 8'h01);
    repeat (4) expect_ev(K_VLD, 8'h01);
    expect_ev(K_END, 8'b10);
    req_len[2:0] = 3'd3;
    req = 4'b0001;
    wait_end("s1");
    req = '0;
    @(negedge clk);
    chk("s1_busy_after", 32'(busy), 32'd0);
    chk("s1_drained", 32'(exq.size()), 32'd0);

    // Round-robin over all four requesters, single-beat bursts.
    do_reset("s2_reset");
    gcyc.delete();
    for (int i = 0; i < 5; i++) begin
      expect_ev(K_GNT, 8'(1 << (i % 4)));
      expect_ev(K_VLD, 8'(1 << (i % 4)));
      expect_ev(K_END, 8'b10);
    end
    req = 4'b1111;
    repeat (5) wait_end("s2");
    req = '0;
    @(negedge clk);
    chk("s2_grant_count", 32'(gcyc.size()), 32'd5);
    for (int i = 1; i < gcyc.size(); i++)
      chk("s2_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);

    // Stall: FIFO empty for 3 cycles after the first read.
    do_reset("s3_reset");
    expect_ev(K_GNT, 8'h02);
    repeat (3) expect_ev(K_VLD, 8'h02);
    expect_ev(K_END, 8'b10);
    req_len[5:3] = 3'd2;
    req = 4'b0010;
    wait_rd("s3");
    @(posedge clk);
    #1 empty = 1'b1;
    repeat (3) tick();
    empty = 1'b0;
    wait_end("s3");
    req = '0;

    // Timeout with FIFO stuck empty, then round-robin pointer lands on 3.
    do_reset("s4_reset");
    gcyc.delete();
    expect_ev(K_GNT, 8'h04);
    expect_ev(K_END, 8'b01);
    empty = 1'b1;
    req = 4'b0100;
    wait_end("s4");
    if (gcyc.size() > 0) chk("s4_timeout_latency", 32'(end_cyc - gcyc[0]), 32'd16);
    else chk("s4_grant_seen", 32'd0, 32'd1);
    expect_ev(K_GNT, 8'h08);
    expect_ev(K_VLD, 8'h08);
    expect_ev(K_END, 8'b10);
    req = 4'b1001;
    empty = 1'b0;
    wait_end("s4b");
    req = '0;

    // Request drop after two reads.
    do_reset("s5_reset");
    expect_ev(K_GNT, 8'h08);
    repeat (2) expect_ev(K_VLD, 8'h08);
    expect_ev(K_END, 8'b01);
    req_len[11:9] = 3'd7;
    req = 4'b1000;
    wait_gnt("s5");
    tick();
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    chk("s5_rd_en_on_drop", 32'(rd_en_sys), 32'd0);
    wait_end("s5");

    // Reset during the second beat discards the burst silently.
    do_reset("s6_reset");
    expect_ev(K_GNT, 8'h02);
    expect_ev(K_VLD, 8'h02);
    req_len[5:3] = 3'd3;
    req = 4'b0010;
    wait_gnt("s6");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("s6_rd_en_in_reset", 32'(rd_en_sys), 32'd0);
    expect_ev(K_GNT, 8'h01);
    expect_ev(K_VLD, 8'h01);
    expect_ev(K_END, 8'b10);
    @(posedge clk);
    #1 rst = 1'b0;
    req_len = '0;
    req = 4'b0011;
    @(negedge clk);
    chk("s6_outputs_after_reset", 32'({rd_en_sys, gnt, data_vld, done, abort, busy}), 32'd0);
    wait_end("s6");
    req = '0;

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
